// File: rtl/game_retract_ctrl_pkg.sv
// rtl/game_retract_ctrl_pkg.sv - shared sel codes, FSM encoding and depth helper for the retract controller
package game_retract_ctrl_pkg;

  typedef enum logic [1:0] {
    SEL_INIT = 2'd0,
    SEL_BM   = 2'd1,
    SEL_MM   = 2'd2,
    SEL_RET  = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_e;

  // History depth after committing one source: init clears, moves grow to dmax, retract shrinks to 0.
  function automatic logic [1:0] depth_after(input logic [1:0] sel,
                                             input logic [1:0] depth,
                                             input int         dmax);
    int nd;
    nd = int'(depth);
    case (sel)
      SEL_INIT: nd = 0;
      SEL_RET:  nd = (nd == 0) ? 0 : nd - 1;
      default:  nd = (nd + 1 > dmax) ? dmax : nd + 1;
    endcase
    return 2'(nd);
  endfunction

endpackage

// File: rtl/game_retract_ctrl_if.sv
// rtl/game_retract_ctrl_if.sv - request/response bundle between the level logic and the retract controller
interface game_retract_ctrl_if;

  logic       init_req;
  logic       bm_req;
  logic       mm_req;
  logic       ret_req;
  logic [1:0] sel;
  logic       game_state_en;
  logic [1:0] undo_depth;
  logic       ack;
  logic       reject;
  logic       busy;

  modport master (
    output init_req, bm_req, mm_req, ret_req,
    input  sel, game_state_en, undo_depth, ack, reject, busy
  );

  modport slave (
    input  init_req, bm_req, mm_req, ret_req,
    output sel, game_state_en, undo_depth, ack, reject, busy
  );

endinterface

// File: rtl/game_retract_ctrl_req_arb.sv
// rtl/game_retract_ctrl_req_arb.sv - combinational fixed-priority request encoder (init > ret > bm > mm)
module game_req_arb
  import game_retract_ctrl_pkg::*;
(
  input  logic       init_req,
  input  logic       ret_req,
  input  logic       bm_req,
  input  logic       mm_req,
  output logic       valid,
  output logic [1:0] sel
);

  always_comb begin
    valid = 1'b1;
    sel   = SEL_INIT;
    if (init_req) begin
      sel = SEL_INIT;
    end else if (ret_req) begin
      sel = SEL_RET;
    end else if (bm_req) begin
      sel = SEL_BM;
    end else if (mm_req) begin
      sel = SEL_MM;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/game_retract_ctrl.sv
// rtl/game_retract_ctrl.sv - sequences state-store loads for init, moves and retract with bounded undo history
module game_retract_ctrl
  import game_retract_ctrl_pkg::*;
#(
  parameter int DEPTH_MAX = 3
) (
  input logic           clk,
  input logic           rst_n,
  game_retract_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] depth_q, depth_d;
  logic       reject_q, reject_d;
  logic       arb_valid;
  logic [1:0] arb_sel;
  logic       any_req;

  game_req_arb u_arb (
    .init_req (bus.init_req),
    .ret_req  (bus.ret_req),
    .bm_req   (bus.bm_req),
    .mm_req   (bus.mm_req),
    .valid    (arb_valid),
    .sel      (arb_sel)
  );

  assign any_req = bus.init_req | bus.bm_req | bus.mm_req | bus.ret_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      sel_q    <= SEL_INIT;
      depth_q  <= 2'd0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      depth_q  <= depth_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    depth_d  = depth_q;
    reject_d = 1'b0;
    case (state_q)
      ST_BOOT: begin
        sel_d   = SEL_INIT;
        depth_d = 2'd0;
        state_d = ST_WAIT_REL;
      end
      ST_IDLE: begin
        if (arb_valid) begin
          sel_d = arb_sel;
          // An empty history cannot be retracted: refuse without touching the store.
          if (arb_sel == SEL_RET && depth_q == 2'd0) begin
            reject_d = 1'b1;
            state_d  = ST_WAIT_REL;
          end else begin
            state_d  = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        depth_d = depth_after(sel_q, depth_q, DEPTH_MAX);
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!any_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Load enable decodes only from state; the rst_n gate kills a load the moment reset asserts.
  assign bus.game_state_en = rst_n & ((state_q == ST_BOOT) | (state_q == ST_COMMIT));
  assign bus.ack           = (state_q == ST_COMMIT);
  assign bus.reject        = reject_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.sel           = sel_q;
  assign bus.undo_depth    = depth_q;

endmodule

// File: doc/game_retract_ctrl.md
GAME_RETRACT_CTRL -- requirements
Module: game_retract_ctrl

Interface
REQ-001 Parameter DEPTH_MAX, default 3: number of retract history slots available in the state store.
REQ-002 Port clk  in  1: single system clock, rising edge.
REQ-003 Port rst_n  in  1: asynchronous, active-low reset.
REQ-004 Port init_req  in  1: level request to reload the level's initial state.
REQ-005 Port bm_req  in  1: level request to commit a box-move result.
REQ-006 Port mm_req  in  1: level request to commit a man-move result.
REQ-007 Port ret_req  in  1: level request to retract one step.
REQ-008 Port sel  out  2: state-store source select; 0=init, 1=box move, 2=man move, 3=retract.
REQ-009 Port game_state_en  out  1: state-store load enable.
REQ-010 Port undo_depth  out  2: count of valid history slots.
REQ-011 Port ack  out  1: one-cycle pulse on each accepted commit.
REQ-012 Port reject  out  1: one-cycle pulse when a retract is refused.
REQ-013 Port busy  out  1: high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be: BOOT, IDLE, COMMIT, WAIT_REL.
REQ-015 BOOT (first cycle after reset release) SHALL:
- drive sel=0 and game_state_en=1 for one cycle;
- set undo_depth=0;
- go to WAIT_REL.
REQ-016 IDLE SHALL sample requests each cycle with fixed priority init > ret > bm > mm, and latch the winner's code into sel.
REQ-017 A winning init, bm or mm SHALL go to COMMIT on the next cycle.
REQ-018 A winning ret with undo_depth=0 SHALL:
- pulse reject in the next cycle;
- go to WAIT_REL;
- not assert game_state_en.
REQ-019 COMMIT SHALL last exactly one cycle, asserting game_state_en=1 and ack=1, then go to WAIT_REL.
REQ-020 Latency SHALL be: request high in IDLE at edge N -> game_state_en high during cycle N+1.
REQ-021 WAIT_REL SHALL hold until all four requests are low for one sampled cycle, then go to IDLE; one key press SHALL produce exactly one commit.
REQ-022 undo_depth SHALL update at COMMIT:
- init: set to 0;
- bm or mm: set to min(depth+1, DEPTH_MAX);
- ret: depth-1, never below 0.
REQ-023 At undo_depth=DEPTH_MAX, a further move SHALL commit normally and the depth SHALL saturate.
REQ-024 sel SHALL hold its last value outside COMMIT and BOOT; game_state_en SHALL be 0 in all other states.
REQ-025 Requests arriving in COMMIT or WAIT_REL SHALL be ignored and never queued.
REQ-026 ack, reject and game_state_en SHALL never be high in the same cycle as one another, except ack with game_state_en in COMMIT.

Reset
REQ-027 rst_n low SHALL immediately force:
- state BOOT;
- sel=0, game_state_en=0;
- undo_depth=0;
- ack=0, reject=0, busy=1.
REQ-028 Reset asserted mid-COMMIT SHALL abort the load; after release, BOOT SHALL reinitialise the state store.

Structure
REQ-029 Sel codes (SEL_INIT, SEL_BM, SEL_MM, SEL_RET) and the FSM state encodings SHALL live in the shared game package, used by both this block and the retract store.
REQ-030 The block SHALL contain one sub-module, game_req_arb: a combinational 4-way fixed-priority encoder producing a valid flag and a sel code.
REQ-031 All registers SHALL be in this block; there SHALL be no combinational path from the request inputs to game_state_en.

Verification
REQ-032 Reset release, no requests -> exactly one cycle with game_state_en=1 and sel=0; undo_depth=0; then IDLE, with busy low after requests are sampled low.
REQ-033 bm_req held high for 10 cycles -> exactly one game_state_en pulse with sel=1 at cycle +1; ack pulses once; undo_depth=1.
REQ-034 Four mm presses, each released between presses -> undo_depth sequence 1,2,3,3; four ack pulses.
REQ-035 At undo_depth=2: ret press -> sel=3 commit, undo_depth=1; two more ret presses -> one commit, then reject with no game_state_en; undo_depth=0.
REQ-036 init_req and ret_req rising in the same cycle at depth 3 -> sel=0 commit, undo_depth=0, no reject.
REQ-037 rst_n pulsed low during COMMIT -> game_state_en drops asynchronously; after release, a BOOT load occurs with sel=0.
